// File: rtl/multi_temp_monitor_pkg.sv
// multi_temp_monitor_pkg: shared states, header byte and flag bit positions (see MULTI_TEMP_CHECKSUM_EN)
package temp_mon_pkg;
    typedef enum logic [2:0] {IDLE, EVAL, HDR, CHID, TEMP, FLAGS, CSUM, NEXT} state_t;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int FLG_ALARM = 0;
    localparam int FLG_SHUT  = 1;
    localparam int FLG_OVR   = 2;
    localparam int FLG_OVER  = 3;
endpackage

// File: rtl/multi_temp_monitor_if.sv
// multi_temp_monitor_if: byte stream valid/ready link towards the UART transmitter
interface multi_temp_monitor_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/multi_temp_monitor_ch_eval.sv
// temp_ch_eval: per-channel hysteresis alarm and saturating over-threshold counter
module temp_ch_eval #(
    parameter int TEMP_W     = 8,
    parameter int SHUT_COUNT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] hi,
    input  logic [TEMP_W-1:0] lo,
    input  logic [TEMP_W-1:0] sh,
    output logic              alarm,
    output logic              over,
    output logic              trip
);
    localparam logic [7:0] SC = 8'(SHUT_COUNT);
    logic [7:0] cnt, nxt;
    logic       ov;
    // next counter value and trip detect for this evaluation
    always_comb begin
        ov   = temp >= sh;
        nxt  = ov ? (cnt == SC ? cnt : cnt + 8'd1) : 8'd0;
        trip = en && nxt == SC;
    end
    // alarm with hysteresis, counter and over flag update on the eval strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm <= 1'b0;
            over  <= 1'b0;
            cnt   <= 8'd0;
        end else if (en) begin
            alarm <= temp >= hi ? 1'b1 : temp <= lo ? 1'b0 : alarm;
            over  <= ov;
            cnt   <= nxt;
        end
    end
endmodule

// File: rtl/multi_temp_monitor.sv
// multi_temp_monitor: N-channel snapshot, alarm/shutdown evaluation and per-channel packet stream (MULTI_TEMP_CHECKSUM_EN adds a checksum byte)
module multi_temp_monitor
    import temp_mon_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TEMP_W     = 8,
    parameter int SHUT_COUNT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*TEMP_W-1:0] adc,
    input  logic                     sample_tick,
    input  logic [TEMP_W-1:0]        alarm_hi,
    input  logic [TEMP_W-1:0]        alarm_lo,
    input  logic [TEMP_W-1:0]        shut_th,
    multi_temp_monitor_if.master     tx,
    output logic [NUM_CH-1:0]        alarm,
    output logic                     shutdown,
    output logic                     busy,
    output logic                     overrun
);
    localparam logic [3:0] LAST = 4'(NUM_CH - 1);
    state_t                    state;
    logic [NUM_CH*TEMP_W-1:0]  adc_q;
    logic [TEMP_W-1:0]         hi_q, lo_q, sh_q;
    logic [3:0]                ch;
    logic [7:0]                data_q;
    logic                      valid_q;
    logic [NUM_CH-1:0]         over, trip;
    logic [15:0]               alarm_x, over_x;
    logic [TEMP_W-1:0]         temps [16];
    logic [7:0]                chid, temp_b, flags;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        temp_ch_eval #(.TEMP_W(TEMP_W), .SHUT_COUNT(SHUT_COUNT)) u_ch (
            .clk   (clk),
            .reset (reset),
            .en    (state == EVAL),
            .temp  (adc_q[i*TEMP_W +: TEMP_W]),
            .hi    (hi_q),
            .lo    (lo_q),
            .sh    (sh_q),
            .alarm (alarm[i]),
            .over  (over[i]),
            .trip  (trip[i])
        );
    end

    // byte candidates for the current channel, padded to 16 slots so the 4-bit index fits
    always_comb begin
        temps = '{default: '0};
        for (int i = 0; i < NUM_CH; i++) temps[i] = adc_q[i*TEMP_W +: TEMP_W];
        alarm_x          = 16'(alarm);
        over_x           = 16'(over);
        chid             = {4'b0, ch};
        temp_b           = 8'(temps[ch]);
        flags            = 8'b0;
        flags[FLG_ALARM] = alarm_x[ch];
        flags[FLG_SHUT]  = shutdown;
        flags[FLG_OVR]   = overrun;
        flags[FLG_OVER]  = over_x[ch];
    end

    // control FSM with registered stream outputs; data only reloads on a transfer so it is stable under stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            adc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sh_q     <= '0;
            ch       <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            shutdown <= 1'b0;
        end else begin
            if (|trip) shutdown <= 1'b1;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_tick) begin
                    adc_q <= adc;
                    hi_q  <= alarm_hi;
                    lo_q  <= alarm_lo;
                    sh_q  <= shut_th;
                    busy  <= 1'b1;
                    state <= EVAL;
                end
                EVAL: begin
                    ch      <= '0;
                    valid_q <= 1'b1;
                    data_q  <= HDR_BYTE;
                    state   <= HDR;
                end
                HDR: if (tx.tx_ready) begin
                    data_q <= chid;
                    state  <= CHID;
                end
                CHID: if (tx.tx_ready) begin
                    data_q <= temp_b;
                    state  <= TEMP;
                end
                TEMP: if (tx.tx_ready) begin
                    data_q <= flags;
                    state  <= FLAGS;
                end
                FLAGS: if (tx.tx_ready) begin
`ifdef MULTI_TEMP_CHECKSUM_EN
                    data_q <= chid ^ temp_b ^ data_q;
                    state  <= CSUM;
`else
                    valid_q <= 1'b0;
                    state   <= NEXT;
`endif
                end
                CSUM: if (tx.tx_ready) begin
                    valid_q <= 1'b0;
                    state   <= NEXT;
                end
                NEXT: if (ch == LAST) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    ch      <= ch + 4'd1;
                    valid_q <= 1'b1;
                    data_q  <= HDR_BYTE;
                    state   <= HDR;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
endmodule

// File: tb/tb_multi_temp_monitor.sv
// tb_multi_temp_monitor: directed checks of stream, hysteresis, shutdown, stall, overrun and reset
module tb_multi_temp_monitor;
    localparam int N = 4;
`ifdef MULTI_TEMP_CHECKSUM_EN
    localparam int PKT = 5;
`else
    localparam int PKT = 4;
`endif
    localparam int BURST = 2 + N * (PKT + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adc = '0;
    logic        sample_tick = 1'b0;
    logic [7:0]  alarm_hi = 8'hF0;
    logic [7:0]  alarm_lo = 8'hE0;
    logic [7:0]  shut_th = 8'hFF;
    logic [3:0]  alarm;
    logic        shutdown, busy, overrun;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  q[$];

    multi_temp_monitor_if tx();

    multi_temp_monitor #(.NUM_CH(N), .TEMP_W(8), .SHUT_COUNT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .adc         (adc),
        .sample_tick (sample_tick),
        .alarm_hi    (alarm_hi),
        .alarm_lo    (alarm_lo),
        .shut_th     (shut_th),
        .tx          (tx),
        .alarm       (alarm),
        .shutdown    (shutdown),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // record every byte that will transfer on the coming edge
    always @(negedge clk) if (!reset && tx.tx_valid && tx.tx_ready) q.push_back(tx.tx_data);

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(int k, int c, logic [7:0] t, logic [7:0] f);
        logic [7:0] id = 8'(c);
        return k == 0 ? 8'hA5 : k == 1 ? id : k == 2 ? t : k == 3 ? f : id ^ t ^ f;
    endfunction

    task automatic chk_pkt(int c, logic [7:0] t, logic [7:0] f);
        for (int k = 0; k < PKT; k++)
            chk($sformatf("pkt_ch%0d_b%0d", c, k), q[c*PKT+k], exp_byte(k, c, t, f));
    endtask

    task automatic tick();
        q.delete();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            cyc();
            n++;
        end
        chk("burst_done", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] hv [4] = '{8'h50, 8'h45, 8'h40, 8'h45};
        logic       ha [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] sv [7] = '{8'h60, 8'h61, 8'h20, 8'h60, 8'h60, 8'h60, 8'h20};
        logic       so [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       ss [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tx.tx_ready = 1'b1;
        cyc(3);
        chk("rst_valid", tx.tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alarm", alarm, 4'h0);
        chk("rst_shutdown", shutdown, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        cyc();

        adc = 32'h10203040;
        tick();
        alarm_hi = 8'h01;
        alarm_lo = 8'h00;
        chk("eval_busy", busy, 1'b1);
        chk("eval_valid", tx.tx_valid, 1'b0);
        cyc();
        chk("hdr_valid", tx.tx_valid, 1'b1);
        chk("hdr_data", tx.tx_data, 8'hA5);
        cyc(BURST - 3);
        chk("busy_before_end", busy, 1'b1);
        cyc();
        chk("busy_at_end", busy, 1'b0);
        chk("basic_qsize", q.size(), N * PKT);
        chk_pkt(0, 8'h40, 8'h00);
        chk_pkt(1, 8'h30, 8'h00);
        chk_pkt(2, 8'h20, 8'h00);
        chk_pkt(3, 8'h10, 8'h00);
        chk("thr_snapshot_alarm", alarm, 4'h0);
        alarm_hi = 8'hF0;
        alarm_lo = 8'hE0;

        tick();
        cyc(13);
        tx.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", tx.tx_data, 8'h20);
            chk("stall_valid", tx.tx_valid, 1'b1);
            cyc();
        end
        tx.tx_ready = 1'b1;
        wait_idle();
        chk("stall_qsize", q.size(), N * PKT);
        chk_pkt(0, 8'h40, 8'h00);
        chk_pkt(1, 8'h30, 8'h00);
        chk_pkt(2, 8'h20, 8'h00);
        chk_pkt(3, 8'h10, 8'h00);

        alarm_hi = 8'h50;
        alarm_lo = 8'h40;
        for (int i = 0; i < 4; i++) begin
            adc = {24'h0, hv[i]};
            tick();
            wait_idle();
            chk("hyst_alarm", alarm, {3'b0, ha[i]});
            chk("hyst_qsize", q.size(), N * PKT);
            chk_pkt(0, hv[i], {7'b0, ha[i]});
        end

        alarm_hi = 8'hF0;
        alarm_lo = 8'hE0;
        shut_th  = 8'h60;
        for (int i = 0; i < 7; i++) begin
            adc = {16'h0, sv[i], 8'h0};
            tick();
            wait_idle();
            chk("shut_level", shutdown, ss[i]);
            chk("shut_qsize", q.size(), N * PKT);
            chk_pkt(1, sv[i], {4'b0, so[i], 1'b0, ss[i], 1'b0});
        end

        adc = '0;
        tick();
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        cyc(7);
        chk("ovr_flags_ch1", tx.tx_data, 8'h06);
        chk("ovr_flags_valid", tx.tx_valid, 1'b1);
        chk("ovr_flags_ch0", q[3], 8'h06);
        reset = 1'b1;
        cyc();
        chk("mid_rst_valid", tx.tx_valid, 1'b0);
        chk("mid_rst_alarm", alarm, 4'h0);
        chk("mid_rst_shutdown", shutdown, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        reset = 1'b0;
        cyc();

        alarm_hi = 8'h70;
        alarm_lo = 8'h10;
        shut_th  = 8'hFF;
        adc = 32'h7F030201;
        tick();
        cyc();
        chk("restart_hdr", tx.tx_data, 8'hA5);
        cyc();
        chk("restart_chid", tx.tx_data, 8'h00);
        cyc(BURST - 4);
        chk("last_next_busy", busy, 1'b1);
        chk("last_next_overrun", overrun, 1'b0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("next_tick_busy", busy, 1'b0);
        chk("next_tick_overrun", overrun, 1'b1);
        cyc(2);
        chk("next_tick_stays_idle", busy, 1'b0);
        chk("restart_qsize", q.size(), N * PKT);
        chk_pkt(0, 8'h01, 8'h00);
        chk_pkt(1, 8'h02, 8'h00);
        chk_pkt(2, 8'h03, 8'h00);
        chk_pkt(3, 8'h7F, 8'h01);
`ifdef MULTI_TEMP_CHECKSUM_EN
        chk("csum_ch3", q[19], 8'h7D);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
